paddsub_seq: RTL and testbench

- Parametrised, multi-cycle signed adder/subtractor with optional saturation.
- Processes operands CHUNK bits per cycle using a carry-chain register, so a wide add needs only a narrow CHUNK-bit ripple adder.
- Valid/ready handshake on both the request and result sides.
- Sits between the register-read stage and result writeback in the datapath experiments; generalises the 1-bit full adder and the fixed 4-bit paddsub.

---
 rtl/paddsub_if.sv | 27 ++
 rtl/paddsub_seq.sv | 135 +++++++++++++
 tb/tb_paddsub_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/paddsub_if.sv
// Request/result handshake bundle for the sequential adder/subtractor.
// The requester uses the master modport, the arithmetic block uses slave.
interface paddsub_if #(
    parameter int WIDTH = 16
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat_en;
    logic [WIDTH-1:0] sum;
    logic             ovfl;
    logic             cout;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, a, b, sub, sat_en, done_ready,
        input  start_ready, sum, ovfl, cout, done_valid
    );

    modport slave (
        input  start_valid, a, b, sub, sat_en, done_ready,
        output start_ready, sum, ovfl, cout, done_valid
    );
endinterface

// File: rtl/paddsub_seq.sv
// Multi-cycle signed adder/subtractor: CHUNK bits per cycle through a carry
// register, with signed-overflow detection and optional saturation.
module paddsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst,
    paddsub_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NCH - 1);
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] raw_r;
    logic [WIDTH-1:0] sum_r;
    logic             sat_r;
    logic             carry_r;
    logic             ovfl_r;
    logic             cout_r;
    logic             done_valid_r;
    logic             start_ready_r;
    logic [IW-1:0]    idx_r;

    int               base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             chunk_cout_s;
    logic [WIDTH-1:0] raw_next_s;
    logic [WIDTH-1:0] final_sum_s;
    logic             final_ovfl_s;

    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Narrow ripple add of the current chunk plus final flag/saturation logic.
    always_comb begin
        base_s      = int'(idx_r) * CHUNK;
        a_chunk_s   = a_r[base_s +: CHUNK];
        b_chunk_s   = b_r[base_s +: CHUNK];
        {chunk_cout_s, chunk_sum_s} = chunk_add(a_chunk_s, b_chunk_s, carry_r);
        raw_next_s  = raw_r;
        raw_next_s[base_s +: CHUNK] = chunk_sum_s;
        // b_r already holds the inverted operand for subtraction
        final_ovfl_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                       (raw_next_s[WIDTH-1] != a_r[WIDTH-1]);
        if (sat_r && final_ovfl_s) begin
            final_sum_s = a_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            final_sum_s = raw_next_s;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            raw_r         <= '0;
            sum_r         <= '0;
            sat_r         <= 1'b0;
            carry_r       <= 1'b0;
            ovfl_r        <= 1'b0;
            cout_r        <= 1'b0;
            done_valid_r  <= 1'b0;
            start_ready_r <= 1'b1;
            idx_r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_r           <= bus.a;
                        b_r           <= bus.b ^ {WIDTH{bus.sub}};
                        sat_r         <= bus.sat_en;
                        carry_r       <= bus.sub;
                        idx_r         <= '0;
                        raw_r         <= '0;
                        start_ready_r <= 1'b0;
                        state_r       <= BUSY;
                    end
                end
                BUSY: begin
                    raw_r   <= raw_next_s;
                    carry_r <= chunk_cout_s;
                    idx_r   <= idx_r + IW'(1'b1);
                    if (idx_r == LAST_IDX) begin
                        sum_r        <= final_sum_s;
                        ovfl_r       <= final_ovfl_s;
                        cout_r       <= chunk_cout_s;
                        done_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    // result registers hold until the next operation completes
                    if (bus.done_ready) begin
                        done_valid_r  <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    done_valid_r  <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.sum         = sum_r;
    assign bus.ovfl        = ovfl_r;
    assign bus.cout        = cout_r;

endmodule

// File: tb/tb_paddsub_seq.sv
// Self-checking bench: directed vectors on a CHUNK=4 instance, then a random
// scoreboard sweep on CHUNK=1/4/16 instances with result backpressure.
module tb_paddsub_seq;
    typedef struct packed {
        logic [15:0] s;
        logic        o;
        logic        c;
    } res_t;

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] es;
        logic        eo;
        logic        ec;
    } vec_t;

    localparam int NRAND   = 334;
    localparam int CYC_MAX = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   rand_go = 1'b0;
    bit   fin [3];
    res_t dq[$];
    vec_t tbl [10];

    always #5 clk = ~clk;

    paddsub_if #(.WIDTH(16)) d ();
    paddsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(d.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic sat);
        int   r;
        res_t o;
        r   = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
        o.o = (r > 32767) || (r < -32768);
        o.c = s ? (x >= y) : ((32'(x) + 32'(y)) > 32'd65535);
        o.s = 16'(r);
        if (sat && o.o) o.s = (r > 0) ? 16'h7FFF : 16'h8000;
        return o;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Entered at posedge+1; issues one request with done_ready=1 and checks it.
    task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input logic tsat, input res_t ex);
        int   n;
        res_t e;
        d.a = ta; d.b = tb_; d.sub = ts; d.sat_en = tsat;
        d.start_valid = 1'b1; d.done_ready = 1'b1;
        n = 0;
        while (!d.start_ready && n < 50) begin @(posedge clk); #1; n++; end
        dq.push_back(ex);
        @(posedge clk); #1;
        d.start_valid = 1'b0; d.a = 16'($urandom); d.b = 16'($urandom);
        n = 0;
        while (!d.done_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_qsize"}, 32'(dq.size()), 32'd1);
        e = (dq.size() > 0) ? dq.pop_front() : ex;
        chk(nm, 32'({d.sum, d.ovfl, d.cout}), 32'(e));
        @(posedge clk); #1;
        chk({nm, "_release"}, 32'({d.done_valid, d.start_ready}), 32'b01);
    endtask

    initial begin
        int n;
        bit seen;
        tbl[0] = '{"add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{"add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[2] = '{"add_ov",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0};
        tbl[3] = '{"add_ov_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0};
        tbl[4] = '{"sub_ov",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{"sub_ov_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
        tbl[6] = '{"sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[7] = '{"sub_minneg", 16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0};
        tbl[8] = '{"add_negsat", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        tbl[9] = '{"sub_zero",   16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1};

        d.start_valid = 1'b0; d.a = '0; d.b = '0; d.sub = 1'b0; d.sat_en = 1'b0; d.done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({d.sum, d.ovfl, d.cout, d.done_valid, d.start_ready}), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start", 32'({d.done_valid, d.start_ready}), 32'b01);

        for (int i = 0; i < 10; i++)
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat,
                  {tbl[i].es, tbl[i].eo, tbl[i].ec});

        // Backpressure: result must hold while inputs churn.
        d.a = 16'h1234; d.b = 16'h4321; d.sub = 1'b0; d.sat_en = 1'b0;
        d.start_valid = 1'b1; d.done_ready = 1'b0;
        @(posedge clk); #1;
        d.start_valid = 1'b0;
        n = 0;
        while (!d.done_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 32'(n), 32'd4);
        for (int k = 0; k < 3; k++) begin
            d.a = 16'($urandom); d.b = 16'($urandom); d.start_valid = ~d.start_valid;
            @(posedge clk); #1;
            chk("bp_hold", 32'({d.sum, d.ovfl, d.cout, d.done_valid, d.start_ready}),
                32'({16'h5555, 1'b0, 1'b0, 1'b1, 1'b0}));
        end
        d.start_valid = 1'b0; d.done_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 32'({d.sum, d.done_valid, d.start_ready}), 32'({16'h5555, 1'b0, 1'b1}));
        do_op("bp_next", 16'h8000, 16'h0001, 1'b1, 1'b1, model(16'h8000, 16'h0001, 1'b1, 1'b1));

        // Reset two cycles into BUSY discards the operation.
        d.a = 16'h1111; d.b = 16'h2222; d.sub = 1'b0; d.start_valid = 1'b1;
        @(posedge clk); #1;
        d.start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_state", 32'({d.sum, d.ovfl, d.cout, d.done_valid, d.start_ready}), 32'h1);
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (d.done_valid) seen = 1'b1; end
        chk("midrst_no_done", 32'(seen), 32'd0);

        rand_go = 1'b1;
        n = 0;
        while (!(fin[0] && fin[1] && fin[2]) && n < 3 * CYC_MAX) begin @(posedge clk); n++; end
        chk("rand_complete", 32'({fin[0], fin[1], fin[2]}), 32'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : rnd
        localparam int CHV = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        paddsub_if #(.WIDTH(16)) rif ();
        paddsub_seq #(.WIDTH(16), .CHUNK(CHV)) rdut (.clk(clk), .rst(rst), .bus(rif.slave));
        res_t rq[$];

        initial begin : drv
            int   sent;
            int   got;
            int   cyc;
            logic acc;
            logic con;
            res_t e;
            rif.start_valid = 1'b0; rif.a = '0; rif.b = '0;
            rif.sub = 1'b0; rif.sat_en = 1'b0; rif.done_ready = 1'b0;
            sent = 0; got = 0; cyc = 0;
            wait (rand_go);
            @(posedge clk); #1;
            while ((got < NRAND) && (cyc < CYC_MAX)) begin
                if (!rif.start_valid && (sent < NRAND) && ($urandom_range(0, 3) != 0)) begin
                    rif.a = rnd_op(); rif.b = rnd_op();
                    rif.sub = 1'($urandom_range(0, 1)); rif.sat_en = 1'($urandom_range(0, 1));
                    rif.start_valid = 1'b1;
                end
                rif.done_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = rif.start_valid && rif.start_ready;
                con = rif.done_valid && rif.done_ready;
                if (con) begin
                    if (rq.size() == 0) begin
                        chk($sformatf("rnd_c%0d_spurious", CHV), 32'(rq.size()), 32'd1);
                    end else begin
                        e = rq.pop_front();
                        chk($sformatf("rnd_c%0d_result", CHV),
                            32'({rif.sum, rif.ovfl, rif.cout}), 32'(e));
                    end
                    got++;
                end
                if (acc) begin
                    rq.push_back(model(rif.a, rif.b, rif.sub, rif.sat_en));
                    sent++;
                end
                @(posedge clk); #1;
                if (acc) rif.start_valid = 1'b0;
                cyc++;
            end
            chk($sformatf("rnd_c%0d_count", CHV), 32'(got), 32'(NRAND));
            chk($sformatf("rnd_c%0d_drain", CHV), 32'(rq.size()), 32'd0);
            fin[g] = 1'b1;
        end
    end

endmodule
